if_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC and issues word fetches to instruction memory over a

---
 rtl/if_stage_pkg.sv | 24 ++
 rtl/if_stage_fetch_skid.sv | 33 +++
 rtl/if_stage.sv | 134 +++++++++++++
 tb/tb_if_stage.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

  // Registered IF->ID payload.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_flow_t;

  // Fetch FSM: RUN = nothing outstanding, WAIT = one live fetch, DRAIN = one fetch to discard.
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t FETCH_RUN   = 2'd0;
  localparam fetch_state_t FETCH_WAIT  = 2'd1;
  localparam fetch_state_t FETCH_DRAIN = 2'd2;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

  // Sequential word address; wraps modulo 2^32.
  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_fetch_skid.sv
// One-entry {pc, instr} holding buffer for a fetch response that arrives while ID is stalled.
module if_stage_fetch_skid
  import if_stage_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_clear,
  input  if_id_flow_t i_flow,
  output logic        o_valid,
  output if_id_flow_t o_flow
);

  logic        r_valid;
  if_id_flow_t r_flow;

  // Clear wins over load; the two never coincide in normal use.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_flow  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_flow  <= i_flow;
    end
  end

  assign o_valid = r_valid;
  assign o_flow  = r_flow;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding word fetches and hands
// {pc, instr} to ID, honouring ID stall and EX/branch redirects.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output if_id_flow_t outflow,
  output logic        outflow_valid
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_pending_pc;
  if_id_flow_t  r_outflow;
  logic         r_outflow_valid;

  logic         w_can_issue;
  logic         w_accept;
  logic         w_rsp_live;
  logic         w_out_load;
  logic         w_skid_valid;
  logic         w_skid_load;
  logic         w_skid_clear;
  if_id_flow_t  w_skid_flow;
  if_id_flow_t  w_rsp_flow;

  // Never request while a redirect lands, while the skid holds data, or while ID holds us off.
  assign w_can_issue    = !redirect_valid && !w_skid_valid && !(r_outflow_valid && stall);
  // In WAIT/DRAIN a new request may only go out in the cycle the outstanding one returns.
  assign imem_req_valid = reset && w_can_issue && ((r_state == FETCH_RUN) || imem_rsp_valid);
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  // A response is only useful if it belongs to a live fetch and no redirect kills it.
  assign w_rsp_live   = (r_state == FETCH_WAIT) && imem_rsp_valid && !redirect_valid;
  assign w_out_load   = !stall || !r_outflow_valid;
  assign w_skid_load  = w_rsp_live && !w_out_load;
  assign w_skid_clear = redirect_valid || (w_out_load && w_skid_valid);
  assign w_rsp_flow   = '{pc: r_pending_pc, instr: imem_rsp_data};

  if_stage_fetch_skid u_skid (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_flow  (w_rsp_flow),
    .o_valid (w_skid_valid),
    .o_flow  (w_skid_flow)
  );

  // Next fetch state: tracks whether the outstanding fetch is live, absent or doomed.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH_RUN: begin
        if (w_accept) w_state_next = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (imem_rsp_valid) begin
          if (redirect_valid)  w_state_next = FETCH_RUN;
          else if (w_accept)   w_state_next = FETCH_WAIT;
          else                 w_state_next = FETCH_RUN;
        end else if (redirect_valid) begin
          w_state_next = FETCH_DRAIN;
        end
      end
      FETCH_DRAIN: begin
        if (imem_rsp_valid) w_state_next = w_accept ? FETCH_WAIT : FETCH_RUN;
      end
      default: w_state_next = FETCH_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= FETCH_RUN;
    else        r_state <= w_state_next;
  end

  // PC bookkeeping: redirect overrides, acceptance advances and remembers the in-flight PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc   <= RESET_PC;
      r_pending_pc <= '0;
    end else begin
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
      end else if (w_accept) begin
        r_fetch_pc <= next_word_addr(r_fetch_pc);
      end
      if (w_accept) r_pending_pc <= r_fetch_pc;
    end
  end

  // Output register: redirect flushes; otherwise skid drains first, then a live response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outflow_valid <= 1'b0;
      r_outflow.pc    <= '0;
      r_outflow.instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      r_outflow_valid <= 1'b0;
      r_outflow.instr <= NOP_INSTR;
    end else if (w_out_load) begin
      if (w_skid_valid) begin
        r_outflow_valid <= 1'b1;
        r_outflow       <= w_skid_flow;
      end else if (w_rsp_live) begin
        r_outflow_valid <= 1'b1;
        r_outflow       <= w_rsp_flow;
      end else begin
        r_outflow_valid <= 1'b0;
        r_outflow.instr <= NOP_INSTR;
      end
    end
  end

  assign outflow       = r_outflow;
  assign outflow_valid = r_outflow_valid;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: queue-based reference model checked every cycle, a latency-programmable
// instruction memory, directed scenarios with literal expectations, and a second instance
// started near the top of the address space to exercise PC wrap.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  if_id_flow_t outflow;
  logic        outflow_valid;

  // Second instance: always ready, 1-cycle memory, no stall/redirect.
  logic        req2_valid;
  logic [31:0] req2_addr;
  logic        rsp2_valid = 1'b0;
  if_id_flow_t outflow2;
  logic        outflow2_valid;
  bit          acc2 = 1'b0;
  logic [31:0] log2[$];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_stage u_dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .outflow        (outflow),
    .outflow_valid  (outflow_valid)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (req2_valid),
    .imem_req_ready (1'b1),
    .imem_req_addr  (req2_addr),
    .imem_rsp_valid (rsp2_valid),
    .imem_rsp_data  (32'h0000_0073),
    .stall          (1'b0),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .outflow        (outflow2),
    .outflow_valid  (outflow2_valid)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction memory for the main instance ----------------
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] rq_addr[$];
  int          rq_due[$];

  always @(negedge clk) begin
    if (reset && imem_req_valid && imem_req_ready) begin
      rq_addr.push_back(imem_req_addr);
      rq_due.push_back(cyc + lat);
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(rq_addr[0]);
      void'(rq_addr.pop_front());
      void'(rq_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
  end

  // ---------------- memory + address log for the wrap instance ----------------
  always @(negedge clk) begin
    acc2 = reset && req2_valid;
    if (!reset) log2.delete();
    else if (req2_valid) log2.push_back(req2_addr);
  end

  always @(posedge clk) begin
    #1;
    rsp2_valid = acc2;
  end

  // ---------------- reference model + per-cycle compare ----------------
  logic [31:0] m_fetch;
  logic [31:0] m_if_pc[$];
  bit          m_if_live[$];
  logic [31:0] m_sk_pc[$];
  logic [31:0] m_sk_instr[$];
  logic        m_ov;
  logic [31:0] m_opc;
  logic [31:0] m_oinstr;
  logic        e_req;
  logic        e_acc;
  logic        rsp_live;
  logic [31:0] rsp_pc;

  always @(negedge clk) begin
    if (!reset) begin
      chk("reset_req_valid", imem_req_valid, 0);
      chk("reset_out_valid", outflow_valid, 0);
      chk("reset_out_pc", outflow.pc, 0);
      chk("reset_out_instr", outflow.instr, NOP);
      m_fetch  = 32'h0;
      m_if_pc.delete();
      m_if_live.delete();
      m_sk_pc.delete();
      m_sk_instr.delete();
      m_ov     = 1'b0;
      m_opc    = 32'h0;
      m_oinstr = NOP;
    end else begin
      e_req = !redirect_valid && (m_sk_pc.size() == 0) && !(m_ov && stall) &&
              ((m_if_pc.size() == 0) || imem_rsp_valid);
      chk("req_valid", imem_req_valid, e_req);
      if (e_req) chk("req_addr", imem_req_addr, m_fetch);
      chk("out_valid", outflow_valid, m_ov);
      chk("out_instr", outflow.instr, m_oinstr);
      if (m_ov) chk("out_pc", outflow.pc, m_opc);

      rsp_live = 1'b0;
      rsp_pc   = 32'h0;
      if (imem_rsp_valid && m_if_pc.size() > 0) begin
        rsp_pc   = m_if_pc.pop_front();
        rsp_live = m_if_live.pop_front() && !redirect_valid;
      end
      e_acc = e_req && imem_req_ready;
      if (redirect_valid) begin
        m_fetch  = redirect_pc;
        m_ov     = 1'b0;
        m_oinstr = NOP;
        m_sk_pc.delete();
        m_sk_instr.delete();
        foreach (m_if_live[i]) m_if_live[i] = 1'b0;
      end else begin
        if (e_acc) begin
          m_if_pc.push_back(m_fetch);
          m_if_live.push_back(1'b1);
          m_fetch = m_fetch + 32'd4;
        end
        if (!stall || !m_ov) begin
          if (m_sk_pc.size() > 0) begin
            m_opc    = m_sk_pc.pop_front();
            m_oinstr = m_sk_instr.pop_front();
            m_ov     = 1'b1;
          end else if (rsp_live) begin
            m_opc    = rsp_pc;
            m_oinstr = instr_of(rsp_pc);
            m_ov     = 1'b1;
          end else begin
            m_ov     = 1'b0;
            m_oinstr = NOP;
          end
        end else if (rsp_live) begin
          m_sk_pc.push_back(rsp_pc);
          m_sk_instr.push_back(instr_of(rsp_pc));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) next_cycle();
    @(negedge clk);
    chk("t1_reset_valid", outflow_valid, 0);
    chk("t1_reset_instr", outflow.instr, 32'h0000_0013);
    chk("t1_reset_req", imem_req_valid, 0);
    next_cycle();

    // Streaming with a 1-cycle memory.
    reset = 1'b1;
    imem_req_ready = 1'b1;
    @(negedge clk);
    chk("t1_first_req", imem_req_valid, 1);
    chk("t1_first_addr", imem_req_addr, 32'h0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("t2_pc0_valid", outflow_valid, 1);
    chk("t2_pc0", outflow.pc, 32'h0);
    chk("t2_instr0", outflow.instr, 32'h5A5A_0000);
    next_cycle();
    @(negedge clk);
    chk("t2_pc4_valid", outflow_valid, 1);
    chk("t2_pc4", outflow.pc, 32'h4);

    // Stall three cycles while pc=8 is presented; pc=C response parks in the skid.
    next_cycle();
    stall = 1'b1;
    @(negedge clk);
    chk("t3_hold_pc", outflow.pc, 32'h8);
    chk("t3_no_req", imem_req_valid, 0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("t3_hold_pc_end", outflow.pc, 32'h8);
    chk("t3_hold_valid", outflow_valid, 1);
    next_cycle();
    stall = 1'b0;
    lat   = 3;
    @(negedge clk);
    chk("t3_skid_blocks_req", imem_req_valid, 0);
    next_cycle();
    @(negedge clk);
    chk("t3_skid_pc", outflow.pc, 32'hC);
    chk("t3_skid_instr", outflow.instr, 32'h5A5A_000C);
    chk("t4_req_10", imem_req_addr, 32'h10);

    // Redirect while the 0x10 fetch is outstanding; its late response must be dropped.
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    chk("t4_redir_no_req", imem_req_valid, 0);
    next_cycle();
    redirect_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    chk("t4_after_redir_valid", outflow_valid, 0);
    chk("t4_drain_no_req", imem_req_valid, 0);
    next_cycle();
    @(negedge clk);
    chk("t4_drop_valid", outflow_valid, 0);
    chk("t4_refetch_addr", imem_req_addr, 32'h100);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("t4_first_valid", outflow_valid, 1);
    chk("t4_first_pc", outflow.pc, 32'h100);
    chk("t4_first_instr", outflow.instr, 32'h5A5A_0100);

    // Stall fills the skid, then redirect and stall together flush everything.
    next_cycle();
    stall = 1'b1;
    @(negedge clk);
    chk("t5_stall_pc", outflow.pc, 32'h104);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    next_cycle();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    @(negedge clk);
    chk("t5_flush_valid", outflow_valid, 0);
    chk("t5_refetch_req", imem_req_valid, 1);
    chk("t5_refetch_addr", imem_req_addr, 32'h200);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("t5_first_pc", outflow.pc, 32'h200);

    // Reset while a slow fetch is outstanding; its response must land in RUN and be ignored.
    next_cycle();
    lat = 3;
    next_cycle();
    reset = 1'b0;
    lat   = 1;
    @(negedge clk);
    chk("t1_mid_req", imem_req_valid, 0);
    chk("t1_mid_valid", outflow_valid, 0);
    chk("t1_mid_instr", outflow.instr, 32'h0000_0013);
    next_cycle();
    reset = 1'b1;
    imem_req_ready = 1'b0;
    @(negedge clk);
    chk("t1_release_addr", imem_req_addr, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("t1_late_rsp_valid", outflow_valid, 0);
    chk("t1_late_rsp_req", imem_req_valid, 1);
    next_cycle();
    imem_req_ready = 1'b1;
    @(negedge clk);
    chk("t6_wrap_out_valid", outflow2_valid, 1);
    chk("t6_wrap_out_pc", outflow2.pc, 32'hFFFF_FFF8);
    chk("t6_wrap_out_instr", outflow2.instr, 32'h0000_0073);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("t1_restart_pc", outflow.pc, 32'h0);
    chk("t1_restart_valid", outflow_valid, 1);
    chk("t6_log_size", (log2.size() >= 3) ? 1 : 0, 1);
    if (log2.size() >= 3) begin
      chk("t6_addr0", log2[0], 32'hFFFF_FFF8);
      chk("t6_addr1", log2[1], 32'hFFFF_FFFC);
      chk("t6_addr2", log2[2], 32'h0000_0000);
    end
    repeat (4) next_cycle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
